// File: rtl/tetris_input.sv
// rtl/tetris_input.sv - button synchroniser, debouncer, auto-repeat and 4-deep event FIFO
// Button order everywhere is {killed, down, change, right, left}; index equals event code.
module tetris_input #(
    parameter int DEB_CYCLES    = 250000,
    parameter int REPEAT_DELAY  = 10000000,
    parameter int REPEAT_PERIOD = 2500000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       left,
    input  logic       right,
    input  logic       change,
    input  logic       down,
    input  logic       killed,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [2:0] evt_code,
    output logic [4:0] held,
    output logic       overflow
);

    localparam int DW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [4:0]    REP_MASK    = 5'b01011;

    logic [4:0]    w_raw;
    logic [4:0]    r_sync1, r_sync2, r_deb, r_deb_q;
    logic [DW-1:0] r_deb_cnt [5];
    logic [RW-1:0] r_rep     [5];
    logic [4:0]    r_first;
    logic [4:0]    w_press, w_rep, w_strobe;
    logic [4:0]    r_pend, w_grant, w_clr;
    logic [2:0]    w_code;
    logic          w_full, w_pop, w_push, r_overflow;
    logic [2:0]    r_mem [4];
    logic [1:0]    r_rd, r_wr;
    logic [2:0]    r_cnt;

    assign w_raw = {killed, down, change, right, left};

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_q <= '0;
            for (int i = 0; i < 5; i++) r_deb_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_deb_q <= r_deb;
            for (int i = 0; i < 5; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_deb[i]     <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_press = r_deb & ~r_deb_q;

    // r_first selects the initial delay; afterwards the counter restarts on each repeat strobe
    always_comb begin
        w_rep = '0;
        for (int i = 0; i < 5; i++)
            w_rep[i] = REP_MASK[i] & r_deb[i] & ~w_press[i] &
                       (r_rep[i] == (r_first[i] ? DELAY_LAST : PERIOD_LAST));
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_first <= '0;
            for (int i = 0; i < 5; i++) r_rep[i] <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (w_press[i]) begin
                    r_rep[i]   <= '0;
                    r_first[i] <= 1'b1;
                end else if (!r_deb[i]) begin
                    r_rep[i] <= '0;
                end else if (w_rep[i]) begin
                    r_rep[i]   <= '0;
                    r_first[i] <= 1'b0;
                end else begin
                    r_rep[i] <= r_rep[i] + 1'b1;
                end
            end
        end
    end

    assign w_strobe = w_press | w_rep;
    assign w_full   = (r_cnt == 3'd4);
    assign w_pop    = (r_cnt != 3'd0) & evt_ready;

    always_comb begin
        w_grant = '0;
        w_code  = 3'd0;
        if (r_pend[4])      begin w_grant = 5'b10000; w_code = 3'd4; end
        else if (r_pend[3]) begin w_grant = 5'b01000; w_code = 3'd3; end
        else if (r_pend[2]) begin w_grant = 5'b00100; w_code = 3'd2; end
        else if (r_pend[0]) begin w_grant = 5'b00001; w_code = 3'd0; end
        else if (r_pend[1]) begin w_grant = 5'b00010; w_code = 3'd1; end
    end

    assign w_push = (!w_full || w_pop) && (r_pend != 5'b00000);
    assign w_clr  = w_push ? w_grant : 5'b00000;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_pend     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_strobe;
            if ((w_strobe & r_pend & ~w_clr) != 5'b00000) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < 4; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= w_code;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + {2'b00, w_push} - {2'b00, w_pop};
        end
    end

    assign evt_valid = (r_cnt != 3'd0);
    assign evt_code  = evt_valid ? r_mem[r_rd] : 3'd0;
    assign held      = r_deb;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_tetris_input.sv
// tb/tb_tetris_input.sv - directed vector bench for tetris_input
// Runs with DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8; edge_n counts edges since reset release.
module tb_tetris_input;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       left = 1'b0, right = 1'b0, change = 1'b0, down = 1'b0, killed = 1'b0;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [2:0] evt_code;
    logic [4:0] held;
    logic       overflow;

    int n_vec  = 0;
    int n_fail = 0;
    int edge_n = 0;

    tetris_input #(.DEB_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) dut (
        .CLK(CLK), .reset(reset),
        .left(left), .right(right), .change(change), .down(down), .killed(killed),
        .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_code(evt_code),
        .held(held), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        logic [4:0] btn;
        logic       rdy;
        int         cycles;
        logic       exp_valid;
        logic [2:0] exp_code;
        logic [4:0] exp_held;
        logic       exp_ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", nm, edge_n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        edge_n++;
    endtask

    task automatic step_to(input int n);
        while (edge_n < n) step();
    endtask

    task automatic set_btn(input logic [4:0] b);
        {killed, down, change, right, left} = b;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_btn(5'b00000);
        evt_ready = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        reset  = 1'b0;
        edge_n = 0;
    endtask

    int ev_edge[$];
    int ev_code[$];
    int exp_rep_edges[6] = '{8, 28, 36, 44, 52, 60};

    initial begin
        // single ROTATE press, then glitch rejection on LEFT
        tbl.push_back('{"reset",      5'b00000, 1'b1, 0,  1'b0, 3'd0, 5'b00000, 1'b0});
        tbl.push_back('{"deb_wait",   5'b00100, 1'b1, 5,  1'b0, 3'd0, 5'b00000, 1'b0});
        tbl.push_back('{"held_rise",  5'b00100, 1'b1, 1,  1'b0, 3'd0, 5'b00100, 1'b0});
        tbl.push_back('{"pend",       5'b00100, 1'b1, 1,  1'b0, 3'd0, 5'b00100, 1'b0});
        tbl.push_back('{"write",      5'b00100, 1'b1, 1,  1'b1, 3'd2, 5'b00100, 1'b0});
        tbl.push_back('{"popped",     5'b00100, 1'b1, 1,  1'b0, 3'd0, 5'b00100, 1'b0});
        tbl.push_back('{"no_repeat",  5'b00100, 1'b1, 21, 1'b0, 3'd0, 5'b00100, 1'b0});
        tbl.push_back('{"rel_wait",   5'b00000, 1'b1, 5,  1'b0, 3'd0, 5'b00100, 1'b0});
        tbl.push_back('{"held_fall",  5'b00000, 1'b1, 1,  1'b0, 3'd0, 5'b00000, 1'b0});
        tbl.push_back('{"idle",       5'b00000, 1'b1, 10, 1'b0, 3'd0, 5'b00000, 1'b0});
        for (int g = 0; g < 3; g++) begin
            tbl.push_back('{"glitch_hi", 5'b00001, 1'b1, 3, 1'b0, 3'd0, 5'b00000, 1'b0});
            tbl.push_back('{"glitch_lo", 5'b00000, 1'b1, 3, 1'b0, 3'd0, 5'b00000, 1'b0});
        end
        tbl.push_back('{"glitch_end", 5'b00000, 1'b1, 8,  1'b0, 3'd0, 5'b00000, 1'b0});

        do_reset();
        check("reset_code", {5'd0, evt_code}, 8'd0);
        foreach (tbl[k]) begin
            set_btn(tbl[k].btn);
            evt_ready = tbl[k].rdy;
            repeat (tbl[k].cycles) step();
            check({tbl[k].name, "_valid"}, {7'd0, evt_valid}, {7'd0, tbl[k].exp_valid});
            check({tbl[k].name, "_held"},  {3'd0, held},      {3'd0, tbl[k].exp_held});
            check({tbl[k].name, "_ovf"},   {7'd0, overflow},  {7'd0, tbl[k].exp_ovf});
            if (tbl[k].exp_valid)
                check({tbl[k].name, "_code"}, {5'd0, evt_code}, {5'd0, tbl[k].exp_code});
        end

        // auto-repeat on RIGHT, raw release after edge 56
        do_reset();
        evt_ready = 1'b1;
        set_btn(5'b00010);
        while (edge_n < 100) begin
            step();
            if (evt_valid) begin
                ev_edge.push_back(edge_n);
                ev_code.push_back(int'(evt_code));
            end
            if (edge_n == 56) set_btn(5'b00000);
        end
        check("rep_count", 8'(ev_edge.size()), 8'd6);
        for (int i = 0; i < 6; i++) begin
            check("rep_edge", (i < ev_edge.size()) ? 8'(ev_edge[i]) : 8'hFF, 8'(exp_rep_edges[i]));
            check("rep_code", (i < ev_code.size()) ? 8'(ev_code[i]) : 8'hFF, 8'd1);
        end

        // simultaneous LEFT, DOWN, KILL: priority order into the FIFO
        do_reset();
        set_btn(5'b11001);
        step_to(7);
        check("prio_pend_valid", {7'd0, evt_valid}, 8'd0);
        step_to(8);
        check("prio_first_valid", {7'd0, evt_valid}, 8'd1);
        check("prio_first_code", {5'd0, evt_code}, 8'd4);
        step_to(10);
        check("prio_head_kept", {5'd0, evt_code}, 8'd4);
        set_btn(5'b00000);
        evt_ready = 1'b1;
        step();
        check("prio_pop2_code", {5'd0, evt_code}, 8'd3);
        step();
        check("prio_pop3_code", {5'd0, evt_code}, 8'd0);
        check("prio_pop3_valid", {7'd0, evt_valid}, 8'd1);
        step();
        check("prio_empty", {7'd0, evt_valid}, 8'd0);
        step_to(30);
        check("prio_quiet", {7'd0, evt_valid}, 8'd0);

        // full FIFO, DOWN merged while blocked, push during pop when full
        do_reset();
        set_btn(5'b00001); step_to(10);
        set_btn(5'b00000); step_to(20);
        set_btn(5'b00010); step_to(30);
        set_btn(5'b00000); step_to(40);
        set_btn(5'b00100); step_to(50);
        set_btn(5'b00000); step_to(60);
        set_btn(5'b01000);
        step_to(70);
        check("full_head_code", {5'd0, evt_code}, 8'd0);
        check("full_held", {3'd0, held}, 8'b01000);
        step_to(90);
        check("full_ovf_before", {7'd0, overflow}, 8'd0);
        step_to(96);
        check("full_ovf_set", {7'd0, overflow}, 8'd1);
        step_to(103);
        set_btn(5'b00000);
        step_to(104);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        check("full_after_pulse_code", {5'd0, evt_code}, 8'd1);
        step_to(115);
        check("full_held_fall", {3'd0, held}, 8'd0);
        check("full_still_head", {5'd0, evt_code}, 8'd1);
        evt_ready = 1'b1;
        step();
        check("full_drain_rot", {5'd0, evt_code}, 8'd2);
        step();
        check("full_drain_down1", {5'd0, evt_code}, 8'd3);
        step();
        check("full_drain_down2", {5'd0, evt_code}, 8'd3);
        check("full_drain_valid", {7'd0, evt_valid}, 8'd1);
        step();
        check("full_drain_empty", {7'd0, evt_valid}, 8'd0);
        check("full_ovf_sticky", {7'd0, overflow}, 8'd1);

        // asynchronous reset with queued events and LEFT held
        do_reset();
        set_btn(5'b00001);
        step_to(60);
        check("rst_pre_valid", {7'd0, evt_valid}, 8'd1);
        check("rst_pre_held", {3'd0, held}, 8'b00001);
        check("rst_pre_ovf", {7'd0, overflow}, 8'd1);
        #3;
        reset = 1'b1;
        #1;
        check("rst_async_valid", {7'd0, evt_valid}, 8'd0);
        check("rst_async_held", {3'd0, held}, 8'd0);
        check("rst_async_ovf", {7'd0, overflow}, 8'd0);
        @(posedge CLK);
        #1;
        reset  = 1'b0;
        edge_n = 0;
        step_to(7);
        check("rst_rel_early", {7'd0, evt_valid}, 8'd0);
        step_to(8);
        check("rst_rel_valid", {7'd0, evt_valid}, 8'd1);
        check("rst_rel_code", {5'd0, evt_code}, 8'd0);
        evt_ready = 1'b1;
        set_btn(5'b00000);
        step();
        check("rst_rel_single", {7'd0, evt_valid}, 8'd0);
        step_to(40);
        check("rst_rel_quiet", {7'd0, evt_valid}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
